// File: rtl/alu_divider_pkg.sv
// Shared types and sizing for the iterative restoring divider.
// ALU_DIVIDER_FPDIV_EN enables signed 16.16 fixed-point divide (op 100).
package alu_divider_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned N_INT     = 32;

`ifdef ALU_DIVIDER_FPDIV_EN
  localparam int unsigned DIV_FRAC  = 16;
  localparam int unsigned N_FP      = 48;
  localparam int unsigned DVD_W     = DIV_WIDTH + DIV_FRAC;
  localparam int unsigned CNT_W     = 6;
`else
  localparam int unsigned DVD_W     = DIV_WIDTH;
  localparam int unsigned CNT_W     = 5;
`endif

  typedef enum logic [2:0] {
    DIV_OP_DIVS   = 3'b000,
    DIV_OP_DIVU   = 3'b001,
    DIV_OP_MODS   = 3'b010,
    DIV_OP_MODU   = 3'b011,
    DIV_OP_FPDIVS = 3'b100
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } div_state_e;

  // Ops whose operands are two's complement and need magnitude/sign handling.
  function automatic logic is_signed_op(input div_op_e op);
    logic s;
    s = 1'b0;
    case (op)
      DIV_OP_DIVS, DIV_OP_MODS: s = 1'b1;
`ifdef ALU_DIVIDER_FPDIV_EN
      DIV_OP_FPDIVS:            s = 1'b1;
`endif
      default:                  s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_divider_div_step.sv
// One combinational radix-2 restoring division step.
module alu_divider_div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W:0]   i_rem,
  input  logic         i_msb,
  input  logic [W-1:0] i_divisor,
  output logic [W:0]   o_rem,
  output logic         o_qbit
);

  logic [W+1:0] w_shift;
  logic [W+1:0] w_div_ext;

  // Full-width shift keeps the compare exact even when the remainder top bit is set.
  always_comb begin
    w_shift   = {i_rem, i_msb};
    w_div_ext = {2'b00, i_divisor};
    o_qbit    = (w_shift >= w_div_ext);
    o_rem     = o_qbit ? (W+1)'(w_shift - w_div_ext) : (W+1)'(w_shift);
  end

endmodule

// File: rtl/alu_divider.sv
// Multi-cycle signed/unsigned divide and modulo beside the CPU ALU.
// Define ALU_DIVIDER_FPDIV_EN to add 16.16 signed fixed-point divide (op 100).
module alu_divider
  import alu_divider_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [DIV_WIDTH-1:0] a,
  input  logic [DIV_WIDTH-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [DIV_WIDTH-1:0] y
);

  div_state_e           r_state;
  div_op_e              r_op;
  logic                 r_sign_a;
  logic                 r_sign_b;
  logic                 r_bzero;
  logic [DIV_WIDTH-1:0] r_divisor;
  logic [DIV_WIDTH:0]   r_rem;
  logic [DVD_W-1:0]     r_dvd;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [DIV_WIDTH-1:0] r_y;

  div_op_e              w_op;
  logic                 w_sign_a;
  logic                 w_sign_b;
  logic [DIV_WIDTH-1:0] w_mag_a;
  logic [DIV_WIDTH-1:0] w_mag_b;
  logic [CNT_W-1:0]     w_last_cnt;
  logic [DIV_WIDTH:0]   w_rem_next;
  logic                 w_qbit;
  logic [DIV_WIDTH-1:0] w_q_mag;
  logic [DIV_WIDTH-1:0] w_r_mag;
  logic [DIV_WIDTH-1:0] w_quot;
  logic [DIV_WIDTH-1:0] w_remd;
  logic [DIV_WIDTH-1:0] w_result;

  assign busy = r_busy;
  assign done = r_done;
  assign y    = r_y;

  // Operand conditioning at request time.
  always_comb begin
    w_op     = div_op_e'(op);
    w_sign_a = is_signed_op(w_op) & a[DIV_WIDTH-1];
    w_sign_b = is_signed_op(w_op) & b[DIV_WIDTH-1];
    w_mag_a  = w_sign_a ? -a : a;
    w_mag_b  = w_sign_b ? -b : b;
  end

  always_comb begin
    w_last_cnt = CNT_W'(N_INT - 1);
`ifdef ALU_DIVIDER_FPDIV_EN
    if (r_op == DIV_OP_FPDIVS) w_last_cnt = CNT_W'(N_FP - 1);
`endif
  end

  alu_divider_div_step #(.W(DIV_WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_msb     (r_dvd[DVD_W-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );

  // Sign fix-up, divide-by-zero results and op select.
  always_comb begin
    w_q_mag  = r_dvd[DIV_WIDTH-1:0];
    w_r_mag  = r_rem[DIV_WIDTH-1:0];
    w_quot   = (r_sign_a ^ r_sign_b) ? -w_q_mag : w_q_mag;
    w_remd   = r_sign_a ? -w_r_mag : w_r_mag;
    w_result = '0;
    case (r_op)
      DIV_OP_DIVS, DIV_OP_DIVU: w_result = r_bzero ? '1 : w_quot;
      DIV_OP_MODS, DIV_OP_MODU: w_result = w_remd;
`ifdef ALU_DIVIDER_FPDIV_EN
      DIV_OP_FPDIVS: begin
        if (r_bzero)
          w_result = r_sign_a ? {1'b1, {(DIV_WIDTH-1){1'b0}}} : {1'b0, {(DIV_WIDTH-1){1'b1}}};
        else
          w_result = w_quot;
      end
`endif
      default: w_result = '0;
    endcase
  end

  // Control FSM; integer operands sit at the top of the dividend register so
  // the quotient always ends up in the low DIV_WIDTH bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_op      <= DIV_OP_DIVS;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_bzero   <= 1'b0;
      r_divisor <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_y       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op      <= w_op;
            r_sign_a  <= w_sign_a;
            r_sign_b  <= w_sign_b;
            r_bzero   <= (b == '0);
            r_divisor <= w_mag_b;
            r_rem     <= '0;
            r_dvd     <= DVD_W'(w_mag_a) << (DVD_W - DIV_WIDTH);
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_rem <= w_rem_next;
          r_dvd <= {r_dvd[DVD_W-2:0], w_qbit};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == w_last_cnt) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_y     <= w_result;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
// Scoreboard bench for alu_divider: directed vectors, latency and handshake checks.
module tb_alu_divider;

  typedef struct {
    logic [31:0] y;
    int          cyc;
    string       name;
  } exp_t;

  localparam logic [2:0] OP_DIVS = 3'b000;
  localparam logic [2:0] OP_DIVU = 3'b001;
  localparam logic [2:0] OP_MODS = 3'b010;
  localparam logic [2:0] OP_MODU = 3'b011;
  localparam logic [2:0] OP_FP   = 3'b100;
  localparam logic [2:0] OP_RSV  = 3'b111;
  localparam int         LAT_INT = 33;
`ifdef ALU_DIVIDER_FPDIV_EN
  localparam int         FP_LAT  = 49;
  localparam bit         FP_EN   = 1'b1;
`else
  localparam int         FP_LAT  = 33;
  localparam bit         FP_EN   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] y;

  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  alu_divider dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .y       (y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 y=%h expected no pending op", y);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_y"}, y, e.y);
        check({e.name, "_lat"}, 32'(cyc), 32'(e.cyc));
        check({e.name, "_busy_at_done"}, 32'(busy), 32'd0);
      end
    end
  end

  task automatic drain(input string nm);
    int i;
    i = 0;
    while (sb.size() != 0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending expected 0", nm, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; accepted on the following posedge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] ey, input int lat, input string nm);
    exp_t e;
    op    = o;
    a     = aa;
    b     = bb;
    start = 1'b1;
    e.y    = ey;
    e.cyc  = cyc + 1 + lat;
    e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy_on"}, 32'(busy), 32'd1);
    drain(nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    exp_t e;
    int   k;
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 3'b000;
    a       = '0;
    b       = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_y", y, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(OP_DIVU, 32'd100,        32'd7,          32'd14,         LAT_INT, "divu_100_7");
    run_op(OP_MODU, 32'd100,        32'd7,          32'd2,          LAT_INT, "modu_100_7");
    run_op(OP_DIVS, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   LAT_INT, "divs_m100_7");
    run_op(OP_MODS, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   LAT_INT, "mods_m100_7");
    run_op(OP_DIVS, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   LAT_INT, "divs_7_m2");
    run_op(OP_MODS, 32'd7,          32'hFFFFFFFE,   32'd1,          LAT_INT, "mods_7_m2");
    run_op(OP_DIVU, 32'hFFFFFFFF,   32'd16,         32'h0FFFFFFF,   LAT_INT, "divu_max_16");
    run_op(OP_MODU, 32'hFFFFFFFF,   32'd16,         32'h0000000F,   LAT_INT, "modu_max_16");
    run_op(OP_DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   LAT_INT, "divu_5_0");
    run_op(OP_DIVS, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   LAT_INT, "divs_m5_0");
    run_op(OP_MODS, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   LAT_INT, "mods_m5_0");
    run_op(OP_MODU, 32'd100,        32'd0,          32'd100,        LAT_INT, "modu_100_0");
    run_op(OP_DIVS, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   LAT_INT, "divs_ovf");
    run_op(OP_MODS, 32'h80000000,   32'hFFFFFFFF,   32'd0,          LAT_INT, "mods_ovf");
    run_op(OP_RSV,  32'd100,        32'd7,          32'd0,          LAT_INT, "reserved_op");
    run_op(OP_FP,   32'h00030000,   32'h00020000,   FP_EN ? 32'h00018000 : 32'd0, FP_LAT, "fp_3_2");
    run_op(OP_FP,   32'hFFFD0000,   32'h00020000,   FP_EN ? 32'hFFFE8000 : 32'd0, FP_LAT, "fp_m3_2");
    run_op(OP_FP,   32'h00012345,   32'd1,          FP_EN ? 32'h23450000 : 32'd0, FP_LAT, "fp_wrap");
    run_op(OP_FP,   32'h00010000,   32'd0,          FP_EN ? 32'h7FFFFFFF : 32'd0, FP_LAT, "fp_pos_0");
    run_op(OP_FP,   32'hFFFF0000,   32'd0,          FP_EN ? 32'h80000000 : 32'd0, FP_LAT, "fp_neg_0");

    // start held high: ignored while busy and in the done cycle, then re-accepted
    op     = OP_DIVU;
    a      = 32'd10;
    b      = 32'd3;
    start  = 1'b1;
    e.y    = 32'd3;
    e.cyc  = cyc + 1 + LAT_INT;
    e.name = "b2b_first";
    sb.push_back(e);
    repeat (5) @(negedge clk);
    a = 32'd99;
    b = 32'd1;
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("b2b_done_seen", 32'(done), 32'd1);
    a      = 32'd9;
    b      = 32'd3;
    e.y    = 32'd3;
    e.cyc  = cyc + 2 + LAT_INT;
    e.name = "b2b_second";
    sb.push_back(e);
    @(negedge clk);
    check("b2b_done_pulse", 32'(done), 32'd0);
    check("b2b_idle_in_gap", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_second", 32'(busy), 32'd1);
    drain("b2b");

    // reset in the middle of an operation
    op    = OP_DIVU;
    a     = 32'd1000;
    b     = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_y", y, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);
    check("midrst_idle", 32'(busy), 32'd0);
    run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_INT, "post_reset_divu");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
